// File: rtl/lcd_pkg.sv
// Shared types, constants and address helpers for the HD44780 responder.
package lcd_pkg;

    localparam int unsigned LINE_LEN    = 40;
    localparam int unsigned DDRAM_DEPTH = 80;
    localparam int unsigned AC_W        = 7;
    localparam logic [7:0]  BLANK       = 8'h20;

    // Instruction opcode masks; the highest set bit selects the instruction.
    localparam logic [7:0] M_SET_DDRAM  = 8'h80;
    localparam logic [7:0] M_SET_CGRAM  = 8'h40;
    localparam logic [7:0] M_FUNC_SET   = 8'h20;
    localparam logic [7:0] M_SHIFT      = 8'h10;
    localparam logic [7:0] M_DISP_CTRL  = 8'h08;
    localparam logic [7:0] M_ENTRY_MODE = 8'h04;
    localparam logic [7:0] M_HOME       = 8'h02;
    localparam logic [7:0] M_CLEAR      = 8'h01;

    localparam logic [AC_W-1:0] AC_L0_LAST  = 7'h27;
    localparam logic [AC_W-1:0] AC_L1_FIRST = 7'h40;
    localparam logic [AC_W-1:0] AC_L1_LAST  = 7'h67;

    typedef enum logic [1:0] {
        S_INIT_CLR,
        S_IDLE,
        S_EXEC,
        S_CLEAR
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_SET_DDRAM,
        OP_SET_CGRAM,
        OP_FUNC_SET,
        OP_SHIFT,
        OP_DISP_CTRL,
        OP_ENTRY_MODE,
        OP_HOME,
        OP_CLEAR
    } op_t;

    // Priority decode of an instruction byte.
    function automatic op_t decode_op(input logic [7:0] b);
        op_t op;
        if      ((b & M_SET_DDRAM)  != 8'h00) op = OP_SET_DDRAM;
        else if ((b & M_SET_CGRAM)  != 8'h00) op = OP_SET_CGRAM;
        else if ((b & M_FUNC_SET)   != 8'h00) op = OP_FUNC_SET;
        else if ((b & M_SHIFT)      != 8'h00) op = OP_SHIFT;
        else if ((b & M_DISP_CTRL)  != 8'h00) op = OP_DISP_CTRL;
        else if ((b & M_ENTRY_MODE) != 8'h00) op = OP_ENTRY_MODE;
        else if ((b & M_HOME)       != 8'h00) op = OP_HOME;
        else if ((b & M_CLEAR)      != 8'h00) op = OP_CLEAR;
        else                                  op = OP_NONE;
        return op;
    endfunction

    // HD44780 address (line in bit 6, column in bits 5:0) to linear DDRAM index.
    function automatic logic [AC_W-1:0] ac_to_idx(input logic [AC_W-1:0] ac);
        logic [AC_W-1:0] col;
        col = {1'b0, ac[5:0]};
        return ac[6] ? col + AC_W'(LINE_LEN) : col;
    endfunction

    // Step the address counter by one, wrapping between the two lines.
    function automatic logic [AC_W-1:0] ac_advance(input logic [AC_W-1:0] ac, input logic inc);
        logic [AC_W-1:0] nxt;
        if (inc) begin
            if (ac == AC_L0_LAST)      nxt = AC_L1_FIRST;
            else if (ac == AC_L1_LAST) nxt = 7'h00;
            else                       nxt = ac + 7'd1;
        end else begin
            if (ac == 7'h00)            nxt = AC_L1_LAST;
            else if (ac == AC_L1_FIRST) nxt = AC_L0_LAST;
            else                        nxt = ac - 7'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display RAM: one write port, registered host and bus read ports.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_we,
    input  logic [AC_W-1:0] i_waddr,
    input  logic [7:0]      i_wdata,
    input  logic [AC_W-1:0] i_host_addr,
    input  logic [AC_W-1:0] i_bus_addr,
    output logic [7:0]      o_host_data,
    output logic [7:0]      o_bus_data
);

    logic [7:0] r_mem [0:DDRAM_DEPTH-1];
    logic [7:0] r_host_data;
    logic [7:0] r_bus_data;

    // Storage write; contents are initialised by the fill sequence, not reset.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Registered reads; host indices past the end read as a blank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_host_data <= 8'h00;
            r_bus_data  <= 8'h00;
        end else begin
            r_host_data <= (i_host_addr < AC_W'(DDRAM_DEPTH)) ? r_mem[i_host_addr] : BLANK;
            r_bus_data  <= r_mem[i_bus_addr];
        end
    end

    assign o_host_data = r_host_data;
    assign o_bus_data  = r_bus_data;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible bus responder: executes driver writes into DDRAM/registers and models busy time.
module lcd_hd44780_responder
    import lcd_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES  = 2000,
    parameter int unsigned CLEAR_CYCLES = 82000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [7:0]  LCD_DATA,
    input  logic        LCD_RW,
    input  logic        LCD_EN,
    input  logic        LCD_RS,
    output logic [7:0]  oLCD_DATA_OUT,
    output logic        oLCD_DATA_OE,
    input  logic [6:0]  iRD_ADDR,
    output logic [7:0]  oRD_DATA,
    output logic        oBUSY,
    output logic [6:0]  oAC,
    output logic        oDISP_ON,
    output logic        oCURSOR_ON,
    output logic        oBLINK_ON,
    output logic        oINC,
    output logic        oSHIFT,
    output logic [2:0]  oFUNC,
    output logic        oCMD_VALID,
    output logic [7:0]  oCMD_BYTE,
    output logic        oCMD_RS,
    output logic        oPROTO_ERR
);

    localparam int unsigned CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [1:0]      r_en_s, r_rw_s, r_rs_s;
    logic [7:0]      r_data_s0, r_data_s1;
    logic            r_en_d, r_evt;
    logic            r_hold_rw, r_hold_rs;
    logic [7:0]      r_hold_data;
    state_t          r_state, w_state_nxt;
    logic            r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [AC_W-1:0] r_fill;
    logic [AC_W-1:0] r_ac;
    logic            r_inc, r_shift, r_disp, r_cursor, r_blink, r_err;
    logic [2:0]      r_func;
    logic            r_cmd_valid, r_cmd_rs;
    logic [7:0]      r_cmd_byte;
    logic            r_oe;
    logic [7:0]      r_dout;

    logic            w_write_evt, w_read_evt, w_accept, w_drop, w_is_clear, w_fill_we;
    logic            w_we, w_rd_active;
    logic [AC_W-1:0] w_waddr;
    logic [7:0]      w_wdata, w_bus_q;
    op_t             w_op;

    // Two-flop synchronisers, hold register and registered EN-fall event.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_en_s      <= '0;
            r_rw_s      <= '0;
            r_rs_s      <= '0;
            r_data_s0   <= '0;
            r_data_s1   <= '0;
            r_en_d      <= 1'b0;
            r_evt       <= 1'b0;
            r_hold_rw   <= 1'b0;
            r_hold_rs   <= 1'b0;
            r_hold_data <= '0;
        end else begin
            r_en_s    <= {r_en_s[0], LCD_EN};
            r_rw_s    <= {r_rw_s[0], LCD_RW};
            r_rs_s    <= {r_rs_s[0], LCD_RS};
            r_data_s0 <= LCD_DATA;
            r_data_s1 <= r_data_s0;
            r_en_d    <= r_en_s[1];
            r_evt     <= r_en_d & ~r_en_s[1];
            if (r_en_s[1]) begin
                r_hold_rw   <= r_rw_s[1];
                r_hold_rs   <= r_rs_s[1];
                r_hold_data <= r_data_s1;
            end
        end
    end

    assign w_write_evt = r_evt & ~r_hold_rw;
    assign w_read_evt  = r_evt &  r_hold_rw;
    assign w_op        = decode_op(r_hold_data);
    assign w_is_clear  = ~r_hold_rs & (w_op == OP_CLEAR);

    // State register; busy mirrors every non-idle state.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= S_INIT_CLR;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // Next state, write acceptance and fill-port control.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_fill_we   = 1'b0;
        case (r_state)
            S_INIT_CLR: begin
                w_fill_we = 1'b1;
                if (r_fill == AC_W'(DDRAM_DEPTH - 1)) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (w_write_evt) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_is_clear ? S_CLEAR : S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cnt == '0) w_state_nxt = S_IDLE;
            end
            S_CLEAR: begin
                w_fill_we = (r_fill < AC_W'(DDRAM_DEPTH));
                if (r_cnt == '0) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_INIT_CLR;
        endcase
        w_drop = w_write_evt & (r_state != S_IDLE);
    end

    // Busy countdown and blank-fill index.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_cnt  <= '0;
            r_fill <= '0;
        end else if (w_accept) begin
            r_cnt  <= w_is_clear ? CNT_W'(CLEAR_CYCLES - 1) : CNT_W'(BUSY_CYCLES - 1);
            r_fill <= '0;
        end else begin
            if (r_cnt != '0) r_cnt  <= r_cnt - CNT_W'(1);
            if (w_fill_we)   r_fill <= r_fill + AC_W'(1);
        end
    end

    // Instruction/data execution, read-side AC advance and error flag.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_ac        <= '0;
            r_inc       <= 1'b1;
            r_shift     <= 1'b0;
            r_func      <= 3'b100;
            r_disp      <= 1'b0;
            r_cursor    <= 1'b0;
            r_blink     <= 1'b0;
            r_err       <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_byte  <= '0;
            r_cmd_rs    <= 1'b0;
        end else begin
            r_cmd_valid <= w_accept;
            if (w_accept) begin
                r_cmd_byte <= r_hold_data;
                r_cmd_rs   <= r_hold_rs;
            end
            if (w_drop) r_err <= 1'b1;
            if (w_accept && r_hold_rs) begin
                r_ac <= ac_advance(r_ac, r_inc);
            end else if (w_accept) begin
                case (w_op)
                    OP_SET_DDRAM: begin
                        if (r_hold_data[5:0] >= 6'(LINE_LEN)) begin
                            r_ac  <= {r_hold_data[6], 6'd0};
                            r_err <= 1'b1;
                        end else begin
                            r_ac <= r_hold_data[6:0];
                        end
                    end
                    OP_FUNC_SET:   r_func <= r_hold_data[4:2];
                    OP_SHIFT:      if (!r_hold_data[3]) r_ac <= ac_advance(r_ac, r_hold_data[2]);
                    OP_DISP_CTRL:  {r_disp, r_cursor, r_blink} <= r_hold_data[2:0];
                    OP_ENTRY_MODE: {r_inc, r_shift} <= r_hold_data[1:0];
                    OP_HOME:       r_ac <= '0;
                    OP_CLEAR: begin
                        r_ac  <= '0;
                        r_inc <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (w_read_evt && r_hold_rs) begin
                r_ac <= ac_advance(r_ac, r_inc);
            end
        end
    end

    assign w_we    = w_fill_we | (w_accept & r_hold_rs);
    assign w_waddr = w_fill_we ? r_fill : ac_to_idx(r_ac);
    assign w_wdata = w_fill_we ? BLANK : r_hold_data;

    lcd_ddram u_ddram (
        .clk         (iCLK),
        .rst_n       (iRST_N),
        .i_we        (w_we),
        .i_waddr     (w_waddr),
        .i_wdata     (w_wdata),
        .i_host_addr (iRD_ADDR),
        .i_bus_addr  (ac_to_idx(r_ac)),
        .o_host_data (oRD_DATA),
        .o_bus_data  (w_bus_q)
    );

    assign w_rd_active = r_en_s[1] & r_rw_s[1];

    // Bus readback: status byte or DDRAM[AC], driven only while a read strobe is up.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_oe   <= 1'b0;
            r_dout <= '0;
        end else begin
            r_oe   <= w_rd_active;
            r_dout <= !w_rd_active ? 8'h00 : (r_rs_s[1] ? w_bus_q : {r_busy, r_ac});
        end
    end

    assign oLCD_DATA_OUT = r_dout;
    assign oLCD_DATA_OE  = r_oe;
    assign oBUSY         = r_busy;
    assign oAC           = r_ac;
    assign oDISP_ON      = r_disp;
    assign oCURSOR_ON    = r_cursor;
    assign oBLINK_ON     = r_blink;
    assign oINC          = r_inc;
    assign oSHIFT        = r_shift;
    assign oFUNC         = r_func;
    assign oCMD_VALID    = r_cmd_valid;
    assign oCMD_BYTE     = r_cmd_byte;
    assign oCMD_RS       = r_cmd_rs;
    assign oPROTO_ERR    = r_err;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Scoreboard bench for lcd_hd44780_responder with a linear-position reference model.
module tb_lcd_hd44780_responder;

    localparam int BUSY_C  = 40;
    localparam int CLEAR_C = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] LCD_DATA = 8'h00;
    logic       LCD_RW = 1'b0, LCD_EN = 1'b0, LCD_RS = 1'b0;
    logic [6:0] iRD_ADDR = 7'h00;
    logic [7:0] oLCD_DATA_OUT, oRD_DATA, oCMD_BYTE;
    logic       oLCD_DATA_OE, oBUSY, oDISP_ON, oCURSOR_ON, oBLINK_ON, oINC, oSHIFT;
    logic       oCMD_VALID, oCMD_RS, oPROTO_ERR;
    logic [6:0] oAC;
    logic [2:0] oFUNC;

    lcd_hd44780_responder #(.BUSY_CYCLES(BUSY_C), .CLEAR_CYCLES(CLEAR_C)) dut (
        .iCLK(clk), .iRST_N(rst_n), .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
        .LCD_RS(LCD_RS), .oLCD_DATA_OUT(oLCD_DATA_OUT), .oLCD_DATA_OE(oLCD_DATA_OE),
        .iRD_ADDR(iRD_ADDR), .oRD_DATA(oRD_DATA), .oBUSY(oBUSY), .oAC(oAC),
        .oDISP_ON(oDISP_ON), .oCURSOR_ON(oCURSOR_ON), .oBLINK_ON(oBLINK_ON), .oINC(oINC),
        .oSHIFT(oSHIFT), .oFUNC(oFUNC), .oCMD_VALID(oCMD_VALID), .oCMD_BYTE(oCMD_BYTE),
        .oCMD_RS(oCMD_RS), .oPROTO_ERR(oPROTO_ERR)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int valid_seen = 0;

    typedef struct packed {
        logic        rs;
        logic [7:0]  b;
        logic [31:0] busy_len;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: linear cursor position 0..79 and a flat 80-byte display.
    logic [7:0] m_mem [80];
    int         m_pos;
    logic       m_inc, m_shift, m_d, m_c, m_b, m_err;
    logic [2:0] m_func;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic int ac_of(input int pos);
        return (pos < 40) ? pos : 64 + pos - 40;
    endfunction

    function automatic void m_blank();
        for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
    endfunction

    function automatic void m_reset();
        m_blank();
        m_pos = 0; m_inc = 1'b1; m_shift = 1'b0; m_func = 3'b100;
        m_d = 1'b0; m_c = 1'b0; m_b = 1'b0; m_err = 1'b0;
    endfunction

    function automatic void m_step(input logic up);
        m_pos = up ? (m_pos + 1) % 80 : (m_pos + 79) % 80;
    endfunction

    // Applies an accepted write to the model; returns the busy time it causes.
    function automatic int m_write(input logic rs, input logic [7:0] d);
        int line, col;
        if (rs) begin
            m_mem[m_pos] = d;
            m_step(m_inc);
            return BUSY_C;
        end
        if (d >= 8'h80) begin
            line = int'(d[6]);
            col  = int'(d[5:0]);
            if (col >= 40) begin m_pos = line * 40; m_err = 1'b1; end
            else m_pos = line * 40 + col;
        end else if (d >= 8'h40) begin
        end else if (d >= 8'h20) begin
            m_func = d[4:2];
        end else if (d >= 8'h10) begin
            if (!d[3]) m_step(d[2]);
        end else if (d >= 8'h08) begin
            m_d = d[2]; m_c = d[1]; m_b = d[0];
        end else if (d >= 8'h04) begin
            m_inc = d[1]; m_shift = d[0];
        end else if (d >= 8'h02) begin
            m_pos = 0;
        end else if (d == 8'h01) begin
            m_blank(); m_pos = 0; m_inc = 1'b1;
            return CLEAR_C;
        end
        return BUSY_C;
    endfunction

    // Monitor: pops the scoreboard on each accepted write and times the busy window.
    initial begin : monitor
        exp_t e;
        int   n;
        forever begin
            @(negedge clk);
            if (rst_n && oCMD_VALID) begin
                valid_seen++;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL cmd_unexpected: got rs=%0d byte=0x%0h expected no write", oCMD_RS, oCMD_BYTE);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_rs", 32'(oCMD_RS), 32'(e.rs));
                    chk("cmd_byte", 32'(oCMD_BYTE), 32'(e.b));
                    n = 0;
                    while (rst_n && oBUSY && n <= CLEAR_C + 10) begin
                        n++;
                        @(negedge clk);
                    end
                    if (rst_n) chk("busy_len", 32'(n), e.busy_len);
                end
            end
        end
    end

    task automatic bus_cycle(input logic rw, input logic rs, input logic [7:0] d);
        @(negedge clk);
        LCD_RW = rw; LCD_RS = rs; LCD_DATA = d; LCD_EN = 1'b1;
        repeat (4) @(negedge clk);
        LCD_EN = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (4) @(negedge clk);
        while (oBUSY && n < CLEAR_C + 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", 32'(oBUSY), 32'd0);
    endtask

    task automatic push_write(input logic rs, input logic [7:0] d);
        exp_t e;
        e.rs = rs; e.b = d;
        e.busy_len = 32'(m_write(rs, d));
        exp_q.push_back(e);
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] d);
        push_write(rs, d);
        bus_cycle(1'b0, rs, d);
        wait_idle();
    endtask

    task automatic bus_read(input logic rs, input logic busy_exp, input string nm);
        logic [7:0] e;
        e = rs ? m_mem[m_pos] : {busy_exp, 7'(ac_of(m_pos))};
        @(negedge clk);
        LCD_RW = 1'b1; LCD_RS = rs; LCD_EN = 1'b1;
        repeat (6) @(negedge clk);
        chk({nm, "_oe"}, 32'(oLCD_DATA_OE), 32'd1);
        chk(nm, 32'(oLCD_DATA_OUT), 32'(e));
        LCD_EN = 1'b0;
        repeat (4) @(negedge clk);
        chk({nm, "_oe_off"}, 32'(oLCD_DATA_OE), 32'd0);
        LCD_RW = 1'b0;
        if (rs) m_step(m_inc);
    endtask

    task automatic host_read(input int a);
        @(negedge clk);
        iRD_ADDR = 7'(a);
        @(negedge clk);
        chk("host_rd", 32'(oRD_DATA), (a < 80) ? 32'(m_mem[a]) : 32'h20);
    endtask

    task automatic check_regs();
        chk("ac", 32'(oAC), 32'(ac_of(m_pos)));
        chk("inc", 32'(oINC), 32'(m_inc));
        chk("shift", 32'(oSHIFT), 32'(m_shift));
        chk("func", 32'(oFUNC), 32'(m_func));
        chk("dcb", 32'({oDISP_ON, oCURSOR_ON, oBLINK_ON}), 32'({m_d, m_c, m_b}));
        chk("proto_err", 32'(oPROTO_ERR), 32'(m_err));
    endtask

    task automatic check_reset_vals();
        chk("rst_busy", 32'(oBUSY), 32'd1);
        chk("rst_ac", 32'(oAC), 32'd0);
        chk("rst_inc", 32'(oINC), 32'd1);
        chk("rst_func", 32'(oFUNC), 32'b100);
        chk("rst_flags", 32'({oDISP_ON, oCURSOR_ON, oBLINK_ON, oSHIFT, oPROTO_ERR}), 32'd0);
        chk("rst_cmd", 32'({oCMD_VALID, oCMD_RS, oCMD_BYTE}), 32'd0);
        chk("rst_bus", 32'({oLCD_DATA_OE, oLCD_DATA_OUT}), 32'd0);
        chk("rst_rd_data", 32'(oRD_DATA), 32'd0);
    endtask

    task automatic release_and_time_init();
        int n;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (oBUSY && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("init_busy_len", 32'(n), 32'd80);
    endtask

    function automatic logic [7:0] rand_instr();
        int t, bp;
        logic [7:0] low;
        t = int'($urandom_range(0, 15));
        if (t == 0) return 8'h01;
        bp  = 1 + (t % 7);
        low = 8'($urandom) & 8'((1 << bp) - 1);
        return 8'(1 << bp) | low;
    endfunction

    initial begin : watchdog
        #3000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int v0;
        int sel;
        m_reset();
        repeat (3) @(negedge clk);
        check_reset_vals();
        release_and_time_init();
        for (int a = 0; a < 80; a++) host_read(a);
        host_read(80);
        host_read(127);
        check_regs();

        // Bring-up sequence
        v0 = valid_seen;
        bus_write(1'b0, 8'h38);
        bus_write(1'b0, 8'h0C);
        bus_write(1'b0, 8'h01);
        bus_write(1'b0, 8'h06);
        bus_write(1'b0, 8'h80);
        bus_write(1'b1, 8'h57);
        chk("six_valids", 32'(valid_seen - v0), 32'd6);
        chk("plan_func", 32'(oFUNC), 32'b110);
        chk("plan_disp", 32'({oDISP_ON, oCURSOR_ON}), 32'b10);
        chk("plan_ac", 32'(oAC), 32'h01);
        host_read(0);
        check_regs();

        // Line wraps, increment and decrement
        bus_write(1'b0, 8'hA7);
        bus_write(1'b1, 8'h41);
        chk("wrap_l0_ac", 32'(oAC), 32'h40);
        host_read(39);
        bus_write(1'b0, 8'hE7);
        bus_write(1'b1, 8'h42);
        chk("wrap_l1_ac", 32'(oAC), 32'h00);
        host_read(79);
        bus_write(1'b0, 8'h04);
        bus_write(1'b1, 8'h58);
        chk("dec_wrap_ac", 32'(oAC), 32'h67);
        host_read(0);
        check_regs();
        bus_write(1'b0, 8'h06);

        // Write while busy is dropped; status read is legal in between
        chk("err_before_drop", 32'(oPROTO_ERR), 32'd0);
        v0 = valid_seen;
        push_write(1'b1, 8'h33);
        bus_cycle(1'b0, 1'b1, 8'h33);
        bus_read(1'b0, 1'b1, "busy_status");
        bus_cycle(1'b0, 1'b1, 8'h99);
        m_err = 1'b1;
        wait_idle();
        chk("drop_valids", 32'(valid_seen - v0), 32'd1);
        host_read(m_pos);
        check_regs();

        // Randomised traffic
        for (int it = 0; it < 150; it++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 35)      bus_write(1'b1, 8'($urandom));
            else if (sel < 70) bus_write(1'b0, rand_instr());
            else if (sel < 80) bus_read(1'b1, 1'b0, "rd_data");
            else if (sel < 88) bus_read(1'b0, 1'b0, "rd_status");
            else               host_read(int'($urandom_range(0, 127)));
            check_regs();
        end
        for (int a = 0; a < 80; a++) host_read(a);

        // Reset in the middle of a clear
        push_write(1'b0, 8'h01);
        bus_cycle(1'b0, 1'b0, 8'h01);
        repeat (96) @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        exp_q.delete();
        repeat (2) @(negedge clk);
        check_reset_vals();
        release_and_time_init();
        for (int a = 0; a < 80; a++) host_read(a);
        check_regs();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_responder.md
# lcd_hd44780_responder

Synthesizable HD44780-compatible responder that sits on the LCD side of the character-LCD bus, opposite `LCD_Controller` and its command sequencers. It samples LCD_DATA/RS/RW on each falling edge of LCD_EN, executes the instruction set into an 80-byte DDRAM and a small register file, and models busy time. Readback runs over the bus (busy flag/address) and over a host read port. It serves as an on-chip loopback target and bench reference for the LCD driver path, and lets DDRAM contents be mirrored onto other displays.

## Interface
- BUSY_CYCLES, 2000: busy duration (in iCLK cycles) for every instruction and data write except clear; must be ≥ 1.
- CLEAR_CYCLES, 82000: busy duration for clear display; must be ≥ 80.
- iCLK  in  1  sole clock.
- iRST_N  in  1  asynchronous, active-low reset.
- LCD_DATA  in  8  bus data from the driver.
- LCD_RW  in  1  1 = read, 0 = write.
- LCD_EN  in  1  strobe; sampled on its falling edge.
- LCD_RS  in  1  0 = instruction, 1 = data.
- oLCD_DATA_OUT  out  8  readback value driven while oLCD_DATA_OE = 1.
- oLCD_DATA_OE  out  1  high while synchronised EN = 1 and RW = 1.
- iRD_ADDR  in  7  host read index into DDRAM, linear 0..79 (line×40 + column).
- oRD_DATA  out  8  DDRAM[iRD_ADDR]; 1-cycle latency. Indices ≥ 80 return 0x20.
- oBUSY  out  1  busy flag.
- oAC  out  7  address counter in HD44780 format (0x00–0x27 for line 0, 0x40–0x67 for line 1).
- oDISP_ON, oCURSOR_ON, oBLINK_ON  out  1 each  display-control bits D, C, B.
- oINC  out  1  entry-mode I/D bit.
- oSHIFT  out  1  entry-mode S bit. Stored only; display shift is not modelled.
- oFUNC  out  3  {DL, N, F} from function set.
- oCMD_VALID  out  1  one-cycle pulse for each accepted write.
- oCMD_BYTE  out  8  byte of the accepted write.
- oCMD_RS  out  1  RS of the accepted write.
- oPROTO_ERR  out  1  sticky error flag; cleared only by reset.

## Operation
- Synchroniser:
  - EN, RW, RS and DATA each pass through 2 flops.
  - RW, RS and DATA are captured into a hold register on every cycle where synchronised EN = 1.
  - A fall of synchronised EN produces an event carrying the held values.
- States:
  - **INIT_CLR.** Entered on reset. Fills DDRAM with 0x20 at one byte per cycle for 80 cycles. oBUSY = 1. Goes to IDLE.
  - **IDLE.** A write event starts execution, then moves to EXEC, or to CLEAR for instruction 0x01. A read event updates nothing except AC on an RS = 1 read.
  - **EXEC.** Counts down BUSY_CYCLES with oBUSY = 1, then returns to IDLE.
  - **CLEAR.** Fills DDRAM with 0x20, sets AC = 0 and I/D = 1. oBUSY = 1 for CLEAR_CYCLES total. Goes to IDLE.
- Instruction decode (RS = 0, highest set bit wins):
  - 1xxxxxxx: set DDRAM address.
  - 01xxxxxx: set CGRAM address. Accepted with no effect.
  - 001xxxxx: function set. oFUNC <= D[4:2].
  - 0001xxxx: shift. If S/C = 0, AC moves by ±1 per R/L. S/C = 1 has no effect.
  - 00001xxx: display control. D, C, B <= D[2:0].
  - 000001xx: entry mode. I/D, S <= D[1:0].
  - 0000001x: return home. AC = 0.
  - 00000001: clear.
- Data write (RS = 1): DDRAM[AC] <= byte, then AC advances by ±1 per I/D.
- AC wrap:
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x00→0x67, 0x40→0x27.
- Invalid set-address (column field ≥ 0x28): AC is set to column 0 of the addressed line and oPROTO_ERR is set.
- Reads:
  - RS = 0: oLCD_DATA_OUT = {oBUSY, oAC}.
  - RS = 1: oLCD_DATA_OUT = DDRAM[AC]; AC advances at the event.
  - Both are legal while busy.
- A write event while oBUSY = 1 (including INIT_CLR) is dropped. oCMD_VALID does not pulse and oPROTO_ERR is set.

## Timing
- Reset values:
  - State = INIT_CLR, oBUSY = 1.
  - oAC = 0, oINC = 1, oFUNC = 3'b100; every other flag output is 0.
  - oLCD_DATA_OE = 0, oLCD_DATA_OUT = 0.
  - oRD_DATA = 0.
- Event detected 3 cycles after the pin fall of EN.
- For an accepted write:
  - oCMD_VALID, the register update and the DDRAM write all land on the event cycle + 1.
  - oBUSY rises on that same cycle.
  - oBUSY stays high exactly BUSY_CYCLES (or CLEAR_CYCLES) cycles.
- After reset release, oBUSY is high for exactly 80 cycles.
- Reset during CLEAR or EXEC aborts it and restarts INIT_CLR.

## Structure
- Package `lcd_pkg`:
  - state enum;
  - instruction opcode masks;
  - the LINE_LEN = 40 and DDRAM_DEPTH = 80 constants;
  - an AC-to-linear-index function and an AC-advance function.
- Sub-module `lcd_ddram`: 80×8 RAM with one write port and two registered read ports (host and bus).

## Test plan
- Reset, then wait 80 cycles → oBUSY falls; all 80 iRD_ADDR reads return 0x20; oAC = 0; oINC = 1.
- Write sequence 0x038, 0x00C, 0x001, 0x006, 0x080, 0x157, spaced 0x3FFFE cycles apart → oFUNC = 3'b110, oDISP_ON = 1, oCURSOR_ON = 0, DDRAM[0] = 0x57, oAC = 0x01; six oCMD_VALID pulses.
- Address wrap:
  - Instruction 0x0A7, then data 0x141 → DDRAM[39] = 0x41, oAC = 0x40.
  - Instruction 0x0E7, then data 0x142 → DDRAM[79] = 0x42, oAC = 0x00.
- Entry mode 0x004 at AC = 0, then data 0x158 → DDRAM[0] = 0x58, oAC = 0x67.
- With BUSY_CYCLES = 2000: a write, then a second write 10 cycles later → second write dropped and oPROTO_ERR = 1. A bus read RW = 1, RS = 0 in between → oLCD_DATA_OUT = 0x80 | oAC while OE = 1.
- Assert reset 100 cycles into a CLEAR → all outputs at reset values; INIT_CLR reruns; oBUSY falls 80 cycles after release.
